arbiter_sync_rr: RTL and testbench

- Parametrised successor to the fixed 4-client synchronous priority arbiter in front of the SDRAM controller.
- Arbitrates CN memory clients (TFT fetch, waveform display, future capture/DMA) onto one memory request port.
- Selectable mode: fixed priority or round-robin.
- Optional burst lock holds a grant for up to LOCK accepted words.
- Routes returned read data to the issuing client by client index.

---
 rtl/arbiter_pkg.sv | 17 +
 rtl/arbiter_sync_rr_if.sv | 41 ++++
 rtl/arbiter_rr_pick.sv | 34 +++
 rtl/arbiter_sync_rr.sv | 133 +++++++++++++
 tb/tb_arbiter_sync_rr.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the synchronous client arbiters.
package arbiter_pkg;

  localparam int unsigned ARB_PRI = 0;
  localparam int unsigned ARB_RR  = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Index width that never collapses to zero for tiny counts.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arbiter_sync_rr_if.sv
// Client-side and memory-side signal bundle for arbiter_sync_rr.
interface arbiter_sync_rr_if
  import arbiter_pkg::*;
#(
  parameter int unsigned AN = 24,
  parameter int unsigned DN = 16,
  parameter int unsigned CN = 4
);
  localparam int unsigned CW = idx_w(CN);

  logic [CN-1:0]         req;
  logic [CN-1:0]         wr;
  logic [CN-1:0][AN-1:0] addr;
  logic [CN-1:0][DN-1:0] data;
  logic [CN-1:0]         ack;
  logic [DN-1:0]         rdata;
  logic [CN-1:0]         valid;

  logic                  m_req;
  logic                  m_wr;
  logic [AN-1:0]         m_addr;
  logic [DN-1:0]         m_data;
  logic [CW-1:0]         m_id;
  logic                  m_ack;
  logic [DN-1:0]         m_rdata;
  logic [CW-1:0]         m_rid;
  logic                  m_valid;

  // Arbiter view.
  modport master (
    input  req, wr, addr, data, m_ack, m_rdata, m_rid, m_valid,
    output ack, rdata, valid, m_req, m_wr, m_addr, m_data, m_id
  );

  // Environment view: clients plus memory controller.
  modport slave (
    output req, wr, addr, data, m_ack, m_rdata, m_rid, m_valid,
    input  ack, rdata, valid, m_req, m_wr, m_addr, m_data, m_id
  );

endinterface

// File: rtl/arbiter_rr_pick.sv
// Combinational winner selection: fixed priority or round-robin after a pointer.
module arbiter_rr_pick
  import arbiter_pkg::*;
#(
  parameter int unsigned CN = 4,
  localparam int unsigned CW = idx_w(CN)
) (
  input  logic [CN-1:0] req,
  input  logic [CW-1:0] ptr,
  input  logic          mode,
  output logic [CW-1:0] win,
  output logic          any
);

  // Scan from the far end so the nearest candidate is assigned last.
  always_comb begin
    win = '0;
    any = |req;
    if (mode) begin
      for (int i = int'(CN); i >= 1; i--) begin
        if (req[(int'(ptr) + i) % int'(CN)]) begin
          win = CW'((int'(ptr) + i) % int'(CN));
        end
      end
    end else begin
      for (int i = int'(CN) - 1; i >= 0; i--) begin
        if (req[i]) begin
          win = CW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/arbiter_sync_rr.sv
// CN-client memory arbiter with fixed/round-robin selection, burst lock and
// read-data routing by returned client index.
module arbiter_sync_rr
  import arbiter_pkg::*;
#(
  parameter int unsigned AN   = 24,
  parameter int unsigned DN   = 16,
  parameter int unsigned CN   = 4,
  parameter int unsigned MODE = 0,
  parameter int unsigned LOCK = 8
) (
  input  logic              clkSYS,
  input  logic              reset,
  arbiter_sync_rr_if.master bus
);

  localparam int unsigned CW  = idx_w(CN);
  localparam int unsigned CTW = idx_w(LOCK + 1);
  localparam logic [CTW-1:0] CNT_LAST = CTW'((LOCK == 0) ? 0 : LOCK - 1);
  localparam logic MODE_RR = (MODE == ARB_RR);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] gnt_q, gnt_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic [CTW-1:0] cnt_q, cnt_d;
  logic [DN-1:0] rdata_q, rdata_d;
  logic [CN-1:0] valid_q, valid_d;

  logic [CW-1:0] win_c;
  logic          any_c;
  logic          hold_c;
  logic [CN-1:0] ack_c;
  logic          m_req_c;
  logic          m_wr_c;
  logic [AN-1:0] m_addr_c;
  logic [DN-1:0] m_data_c;
  logic [CW-1:0] m_id_c;

  arbiter_rr_pick #(.CN(CN)) u_pick (
    .req  (bus.req),
    .ptr  (ptr_q),
    .mode (MODE_RR),
    .win  (win_c),
    .any  (any_c)
  );

  // Grant FSM and the memory-port mux driven from the held grant.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    hold_c   = 1'b0;
    ack_c    = '0;
    m_req_c  = 1'b0;
    m_wr_c   = 1'b0;
    m_addr_c = '0;
    m_data_c = '0;
    m_id_c   = '0;
    unique case (state_q)
      IDLE: begin
        if (any_c) begin
          state_d = GRANT;
          gnt_d   = win_c;
          ptr_d   = win_c;
        end
      end
      GRANT: begin
        hold_c        = bus.req[gnt_q];
        m_req_c       = hold_c;
        m_wr_c        = bus.wr[gnt_q];
        m_addr_c      = bus.addr[gnt_q];
        m_data_c      = bus.data[gnt_q];
        m_id_c        = gnt_q;
        ack_c[gnt_q]  = bus.m_ack & hold_c;
        if (!hold_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (bus.m_ack) begin
          if ((LOCK != 0) && (cnt_q == CNT_LAST)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CTW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read return is independent of the grant state.
  always_comb begin
    rdata_d = rdata_q;
    valid_d = '0;
    if (bus.m_valid) begin
      rdata_d = bus.m_rdata;
      for (int i = 0; i < int'(CN); i++) begin
        if (bus.m_rid == CW'(i)) begin
          valid_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clkSYS or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= CW'(CN - 1);
      cnt_q   <= '0;
      rdata_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
    end
  end

  assign bus.ack    = ack_c;
  assign bus.m_req  = m_req_c;
  assign bus.m_wr   = m_wr_c;
  assign bus.m_addr = m_addr_c;
  assign bus.m_data = m_data_c;
  assign bus.m_id   = m_id_c;
  assign bus.rdata  = rdata_q;
  assign bus.valid  = valid_q;

endmodule

// File: tb/tb_arbiter_sync_rr.sv
// Directed bench for arbiter_sync_rr: three instances cover priority/LOCK 8,
// round-robin/LOCK 2 and hold-while-requesting (LOCK 0).
module tb_arbiter_sync_rr;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  arbiter_sync_rr_if #(.AN(24), .DN(16), .CN(4)) ifa ();
  arbiter_sync_rr_if #(.AN(24), .DN(16), .CN(4)) ifb ();
  arbiter_sync_rr_if #(.AN(24), .DN(16), .CN(4)) ifc ();

  arbiter_sync_rr #(.AN(24), .DN(16), .CN(4), .MODE(0), .LOCK(8)) dut_a (
    .clkSYS (clk), .reset (rst), .bus (ifa));
  arbiter_sync_rr #(.AN(24), .DN(16), .CN(4), .MODE(1), .LOCK(2)) dut_b (
    .clkSYS (clk), .reset (rst), .bus (ifb));
  arbiter_sync_rr #(.AN(24), .DN(16), .CN(4), .MODE(0), .LOCK(0)) dut_c (
    .clkSYS (clk), .reset (rst), .bus (ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    int       acks;
    int       k;
    int       rr_seq[14];
    logic [3:0] exp_ack;

    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    ifa.req = '0; ifa.wr = '0; ifa.addr = '0; ifa.data = '0;
    ifa.m_ack = 1'b0; ifa.m_rdata = '0; ifa.m_rid = '0; ifa.m_valid = 1'b0;
    ifb.req = '0; ifb.wr = '0; ifb.addr = '0; ifb.data = '0;
    ifb.m_ack = 1'b0; ifb.m_rdata = '0; ifb.m_rid = '0; ifb.m_valid = 1'b0;
    ifc.req = '0; ifc.wr = '0; ifc.addr = '0; ifc.data = '0;
    ifc.m_ack = 1'b0; ifc.m_rdata = '0; ifc.m_rid = '0; ifc.m_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ifa.addr[i] = 24'h100000 + 24'(i * 16'h111);
      ifa.data[i] = 16'hA000 + 16'(i);
    end
    ifa.wr = 4'b0100;

    // Reset state
    step();
    chk("rst_m_req", 32'(ifa.m_req), 0);
    chk("rst_ack", 32'(ifa.ack), 0);
    chk("rst_valid", 32'(ifa.valid), 0);
    chk("rst_rdata", 32'(ifa.rdata), 0);
    chk("rst_m_id", 32'(ifa.m_id), 0);
    chk("rst_m_addr", 32'(ifa.m_addr), 0);
    rst = 1'b0;

    // Fixed priority: 1100 -> client 2, then client 3 after one IDLE
    ifa.req = 4'b1100;
    step();
    chk("pri_m_req", 32'(ifa.m_req), 1);
    chk("pri_m_id", 32'(ifa.m_id), 2);
    chk("pri_m_addr", 32'(ifa.m_addr), 32'h100222);
    chk("pri_m_data", 32'(ifa.m_data), 32'hA002);
    chk("pri_m_wr", 32'(ifa.m_wr), 1);
    chk("pri_ack_lo", 32'(ifa.ack), 0);
    ifa.m_ack = 1'b1;
    #1 chk("pri_ack_hi", 32'(ifa.ack), 32'b0100);
    step();
    ifa.m_ack = 1'b0;
    ifa.req   = 4'b1000;
    #1 chk("pri_drop_m_req", 32'(ifa.m_req), 0);
    step();
    chk("pri_bubble", 32'(ifa.m_req), 0);
    step();
    chk("pri_next_req", 32'(ifa.m_req), 1);
    chk("pri_next_id", 32'(ifa.m_id), 3);
    chk("pri_next_addr", 32'(ifa.m_addr), 32'h100333);
    ifa.req = 4'b0000;
    step();
    chk("pri_release", 32'(ifa.m_req), 0);

    // LOCK 8: client 3 keeps the grant although client 0 rises mid-burst
    ifa.req   = 4'b1000;
    ifa.m_ack = 1'b1;
    step();
    acks = 0;
    k    = 0;
    while (ifa.m_req && ifa.m_id == 2'd3 && k < 20) begin
      if (ifa.ack[3]) acks++;
      if (acks == 4) ifa.req = 4'b1001;
      step();
      k++;
    end
    chk("lock8_acks", 32'(acks), 8);
    chk("lock8_bubble", 32'(ifa.m_req), 0);
    step();
    chk("lock8_next_req", 32'(ifa.m_req), 1);
    chk("lock8_next_id", 32'(ifa.m_id), 0);
    chk("lock8_next_ack", 32'(ifa.ack), 32'b0001);
    ifa.req   = 4'b0000;
    ifa.m_ack = 1'b0;
    step();
    step();

    // Read routing
    ifa.m_valid = 1'b1;
    ifa.m_rid   = 2'd3;
    ifa.m_rdata = 16'hBEEF;
    #1 chk("rd_lat_valid", 32'(ifa.valid), 0);
    step();
    chk("rd_valid", 32'(ifa.valid), 32'b1000);
    chk("rd_rdata", 32'(ifa.rdata), 32'hBEEF);
    ifa.m_valid = 1'b0;
    ifa.m_rdata = 16'h1234;
    step();
    chk("rd_valid_clr", 32'(ifa.valid), 0);
    chk("rd_rdata_hold", 32'(ifa.rdata), 32'hBEEF);
    ifa.m_valid = 1'b1;
    ifa.m_rid   = 2'd0;
    step();
    ifa.m_valid = 1'b0;
    chk("rd0_valid", 32'(ifa.valid), 32'b0001);
    chk("rd0_rdata", 32'(ifa.rdata), 32'h1234);

    // Round-robin, LOCK 2, all requesting: 0,0,-,1,1,-,2,2,-,3,3,-,0,0
    rr_seq = '{0, 0, -1, 1, 1, -1, 2, 2, -1, 3, 3, -1, 0, 0};
    ifb.req   = 4'b1111;
    ifb.m_ack = 1'b1;
    step();
    for (int i = 0; i < 14; i++) begin
      if (rr_seq[i] < 0) begin
        chk($sformatf("rr_idle_%0d", i), 32'(ifb.m_req), 0);
        chk($sformatf("rr_idle_ack_%0d", i), 32'(ifb.ack), 0);
      end else begin
        exp_ack = 4'b0001 << rr_seq[i];
        chk($sformatf("rr_req_%0d", i), 32'(ifb.m_req), 1);
        chk($sformatf("rr_id_%0d", i), 32'(ifb.m_id), 32'(rr_seq[i]));
        chk($sformatf("rr_ack_%0d", i), 32'(ifb.ack), 32'(exp_ack));
      end
      step();
    end
    ifb.req   = 4'b0000;
    ifb.m_ack = 1'b0;
    step();
    step();

    // Reset in the middle of a grant to client 2
    ifb.req = 4'b0100;
    step();
    chk("rst_mid_id", 32'(ifb.m_id), 2);
    chk("rst_mid_req", 32'(ifb.m_req), 1);
    ifb.m_ack   = 1'b1;
    ifb.m_valid = 1'b1;
    ifb.m_rid   = 2'd1;
    ifb.m_rdata = 16'h5A5A;
    step();
    chk("rst_mid_valid", 32'(ifb.valid), 32'b0010);
    chk("rst_mid_ack", 32'(ifb.ack), 32'b0100);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_m_req", 32'(ifb.m_req), 0);
    chk("rst_async_ack", 32'(ifb.ack), 0);
    chk("rst_async_valid", 32'(ifb.valid), 0);
    ifb.m_ack   = 1'b0;
    ifb.m_valid = 1'b0;
    ifb.req     = 4'b0110;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_req", 32'(ifb.m_req), 1);
    chk("post_rst_id", 32'(ifb.m_id), 1);
    ifb.req = 4'b0000;
    step();
    step();

    // LOCK 0: client 1 holds the grant for 20 acks, no bubble
    ifc.req   = 4'b0010;
    ifc.m_ack = 1'b1;
    step();
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      if (ifc.m_req && ifc.m_id == 2'd1 && ifc.ack == 4'b0010) acks++;
      step();
    end
    chk("lock0_acks", 32'(acks), 20);
    chk("lock0_still_req", 32'(ifc.m_req), 1);
    ifc.req = 4'b0000;
    #1 chk("lock0_drop", 32'(ifc.m_req), 0);
    step();
    chk("lock0_idle", 32'(ifc.m_req), 0);
    ifc.m_ack = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
